// File: rtl/probe_capture.sv
// Edge-sampled change logger: every new probe value is stored with its timestamp
// in a small circular FIFO drained through a valid/ready port.
module probe_capture #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int TS_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [WIDTH-1:0]       probe,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [TS_WIDTH-1:0]    out_ts,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [7:0]             overflow_cnt
);

   localparam int AW = $clog2(DEPTH);

   logic [TS_WIDTH-1:0] ts_q;
   logic [WIDTH-1:0]    last_q;
   logic                armed;
   logic [AW:0]         wr_ptr;
   logic [AW:0]         rd_ptr;

   logic [WIDTH-1:0]    data_mem [DEPTH];
   logic [TS_WIDTH-1:0] ts_mem   [DEPTH];

   logic capture;
   logic full;
   logic empty;
   logic pop;
   logic push;
   logic drop;

   assign capture = en && (armed || (probe != last_q));
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = !empty && out_ready;
   // A pop on the same edge frees the slot the full-FIFO push lands in.
   assign push    = capture && (!full || pop);
   assign drop    = capture && full && !pop;

   assign out_valid  = !empty;
   assign fifo_count = wr_ptr - rd_ptr;
   assign out_data   = empty ? '0 : data_mem[rd_ptr[AW-1:0]];
   assign out_ts     = empty ? '0 : ts_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr[AW-1:0]] <= probe;
         ts_mem[wr_ptr[AW-1:0]]   <= ts_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_q         <= '0;
         last_q       <= '0;
         armed        <= 1'b1;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         overflow_cnt <= '0;
      end else begin
         if (en) begin
            ts_q   <= ts_q + 1'b1;
            last_q <= probe;
         end
         // Disabling re-arms so the next enabled edge logs a baseline entry.
         armed <= !en;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (drop && (overflow_cnt != 8'hFF))
            overflow_cnt <= overflow_cnt + 1'b1;
      end
   end

endmodule
